// File: rtl/dm9000a_iow_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : dm9000a_iow_arbiter
// Purpose : Round-robin sharing of one DM9000A IOW engine among NUM_REQ requesters
// Revision: 1.0
// ============================================================================
module dm9000a_iow_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   iDm9000aClk,
  input  logic                   iRst,
  input  logic [NUM_REQ-1:0]     iReqRunStart,
  input  logic [NUM_REQ*16-1:0]  iReqReg,
  input  logic [NUM_REQ*16-1:0]  iReqData,
  output logic [NUM_REQ-1:0]     oReqRunEnd,
  output logic [NUM_REQ-1:0]     oGrant,
  output logic                   oTimeout,
  output logic                   out_to_Dm9000a_Iow_RunStart,
  output logic [15:0]            out_to_Dm9000a_Iow_Reg,
  output logic [15:0]            out_to_Dm9000a_Iow_Data,
  input  logic                   in_from_Dm9000a_Iow_RunEnd
);

  localparam int c_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_WDOG_W = $clog2(TIMEOUT_CYC);
  localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYC - 1);
  localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_IDX_W-1:0]    r_rrPtr;
  logic [c_IDX_W-1:0]    r_gIdx;
  logic [c_WDOG_W-1:0]   r_wdog;

  logic                  w_selValid;
  logic [c_IDX_W-1:0]    w_selIdx;
  int                    w_cand;

  // Scan from the farthest rotation offset down so the nearest-to-rrPtr request wins.
  always_comb begin
    w_selValid = 1'b0;
    w_selIdx   = '0;
    w_cand     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = int'(r_rrPtr) + i;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (iReqRunStart[w_cand[c_IDX_W-1:0]]) begin
        w_selValid = 1'b1;
        w_selIdx   = w_cand[c_IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge iDm9000aClk or posedge iRst) begin
    if (iRst) begin
      r_state                     <= S_IDLE;
      r_rrPtr                     <= '0;
      r_gIdx                      <= '0;
      r_wdog                      <= '0;
      oReqRunEnd                  <= '0;
      oGrant                      <= '0;
      oTimeout                    <= 1'b0;
      out_to_Dm9000a_Iow_RunStart <= 1'b0;
      out_to_Dm9000a_Iow_Reg      <= '0;
      out_to_Dm9000a_Iow_Data     <= '0;
    end else begin
      oTimeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Never raise RunStart while the engine still reports a completion.
          if (w_selValid && !in_from_Dm9000a_Iow_RunEnd) begin
            r_gIdx                      <= w_selIdx;
            oGrant                      <= '0;
            oGrant[w_selIdx]            <= 1'b1;
            out_to_Dm9000a_Iow_Reg      <= iReqReg[{w_selIdx, 4'b0000} +: 16];
            out_to_Dm9000a_Iow_Data     <= iReqData[{w_selIdx, 4'b0000} +: 16];
            out_to_Dm9000a_Iow_RunStart <= 1'b1;
            r_wdog                      <= '0;
            r_state                     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wdog <= r_wdog + 1'b1;
          if (in_from_Dm9000a_Iow_RunEnd) begin
            out_to_Dm9000a_Iow_RunStart <= 1'b0;
            oReqRunEnd[r_gIdx]          <= 1'b1;
            r_state                     <= S_ACK;
          end else if (r_wdog == c_WDOG_LAST) begin
            out_to_Dm9000a_Iow_RunStart <= 1'b0;
            oTimeout                    <= 1'b1;
            oReqRunEnd[r_gIdx]          <= 1'b1;
            r_state                     <= S_ACK;
          end else if (!iReqRunStart[r_gIdx]) begin
            out_to_Dm9000a_Iow_RunStart <= 1'b0;
            r_state                     <= S_RELEASE;
          end
        end
        S_ACK: begin
          if (!iReqRunStart[r_gIdx]) begin
            oReqRunEnd <= '0;
            r_state    <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          out_to_Dm9000a_Iow_Reg  <= '0;
          out_to_Dm9000a_Iow_Data <= '0;
          if (!in_from_Dm9000a_Iow_RunEnd) begin
            oGrant  <= '0;
            r_rrPtr <= (r_gIdx == c_LAST_IDX) ? '0 : r_gIdx + 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm9000a_iow_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_dm9000a_iow_arbiter
// Purpose : Randomised scoreboard bench for the IOW round-robin arbiter
// Revision: 1.0
// ============================================================================
module tb_dm9000a_iow_arbiter;
  localparam int N   = 3;
  localparam int TMO = 16;
  localparam int K_NORMAL = 0, K_TIMEOUT = 1, K_ABORT = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    reqRunStart;
  logic [N*16-1:0] reqReg, reqData;
  logic [N-1:0]    reqRunEnd, grant;
  logic            timeoutP, iowRunStart, iowRunEnd;
  logic [15:0]     iowReg, iowData;

  dm9000a_iow_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .iDm9000aClk                 (clk),
    .iRst                        (rst),
    .iReqRunStart                (reqRunStart),
    .iReqReg                     (reqReg),
    .iReqData                    (reqData),
    .oReqRunEnd                  (reqRunEnd),
    .oGrant                      (grant),
    .oTimeout                    (timeoutP),
    .out_to_Dm9000a_Iow_RunStart (iowRunStart),
    .out_to_Dm9000a_Iow_Reg      (iowReg),
    .out_to_Dm9000a_Iow_Data     (iowData),
    .in_from_Dm9000a_Iow_RunEnd  (iowRunEnd)
  );

  always #20 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] regv;
    logic [15:0] datav;
    int          kind;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  int   planKind[N], planParam[N], gcnt[N], hold[N];
  int   modelPtr = 0;
  bit   engBusy = 1'b0;
  int   engCnt = 0, engIdx = 0, engDrop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit   prevRS = 1'b0, inFlight = 1'b0, abortWatch = 1'b0;
  exp_t cur;
  int   lat = 0, lowCnt = 99;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("reset_outputs", 64'({grant, reqRunEnd, timeoutP, iowRunStart, iowReg, iowData}), 64'(0));
      prevRS = 1'b0; inFlight = 1'b0; abortWatch = 1'b0; lowCnt = 99;
    end else begin
      if (iowRunStart && !prevRS) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: got grant 0x%0h, expected no new grant", grant);
        end else begin
          cur = sbq.pop_front();
          chk("grant", 64'(grant), 64'(1 << cur.idx));
          chk("iow_reg", 64'(iowReg), 64'(cur.regv));
          chk("iow_data", 64'(iowData), 64'(cur.datav));
          chk("engine_idle_at_start", 64'(iowRunEnd), 64'(0));
          chk("gap_before_start", 64'(lowCnt >= 2), 64'(1));
          inFlight = 1'b1; lat = 0; abortWatch = 1'b0;
        end
      end else if (iowRunStart && inFlight) begin
        lat++;
        chk("iow_reg_frozen", 64'(iowReg), 64'(cur.regv));
        chk("iow_data_frozen", 64'(iowData), 64'(cur.datav));
        chk("no_early_timeout", 64'(timeoutP), 64'(0));
      end else if (!iowRunStart && prevRS && inFlight) begin
        lat++;
        chk("issue_length", 64'(lat), 64'(cur.lat));
        chk("timeout_pulse", 64'(timeoutP), 64'(cur.kind == K_TIMEOUT));
        chk("runend_at_end", 64'(reqRunEnd), (cur.kind == K_ABORT) ? 64'(0) : 64'(1 << cur.idx));
        chk("grant_held", 64'(grant), 64'(1 << cur.idx));
        abortWatch = (cur.kind == K_ABORT);
        inFlight = 1'b0;
      end else begin
        chk("no_stray_timeout", 64'(timeoutP), 64'(0));
      end
      if (abortWatch) begin
        if (grant == '0) abortWatch = 1'b0;
        else chk("aborted_no_runend", 64'(reqRunEnd), 64'(0));
      end
      chk("runend_only_owner", 64'(((reqRunEnd & ~grant) == '0) && ($countones(reqRunEnd) <= 1)), 64'(1));
      lowCnt = iowRunStart ? 0 : lowCnt + 1;
      prevRS = iowRunStart;
    end
  end

  // ---------------- requester + engine behaviour (called at negedge) ----------------
  task automatic stepAgents();
    if (iowRunStart) begin
      if (!engBusy) begin
        engBusy = 1'b1; engCnt = 0;
        for (int k = 0; k < N; k++) if (grant[k]) engIdx = k;
      end else begin
        engCnt++;
      end
      if (planKind[engIdx] == K_NORMAL && engCnt == planParam[engIdx] && !iowRunEnd) begin
        iowRunEnd = 1'b1;
        engDrop   = int'($urandom_range(0, 2));
      end
    end else if (engBusy) begin
      if (!iowRunEnd) engBusy = 1'b0;
      else if (engDrop == 0) begin iowRunEnd = 1'b0; engBusy = 1'b0; end
      else engDrop--;
    end
    for (int k = 0; k < N; k++) begin
      if (reqRunStart[k]) begin
        if (reqRunEnd[k]) begin
          if (hold[k] == 0) reqRunStart[k] = 1'b0;
          else hold[k]--;
        end else if (grant[k] && iowRunStart) begin
          if (planKind[k] == K_ABORT && gcnt[k] == planParam[k]) reqRunStart[k] = 1'b0;
          gcnt[k]++;
          if ($urandom_range(0, 1) == 1) begin
            reqReg[16*k +: 16]  = 16'($urandom);
            reqData[16*k +: 16] = 16'($urandom);
          end
        end
      end
    end
  endtask

  task automatic plan(input int k, input int kind, input int param,
                      input logic [15:0] regv, input logic [15:0] datav);
    planKind[k]  = kind;
    planParam[k] = param;
    gcnt[k]      = 0;
    hold[k]      = int'($urandom_range(0, 2));
    reqReg[16*k +: 16]  = regv;
    reqData[16*k +: 16] = datav;
  endtask

  task automatic randPlan(input int k);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6)      plan(k, K_NORMAL, int'($urandom_range(1, TMO - 1)), 16'($urandom), 16'($urandom));
    else if (r < 8) plan(k, K_TIMEOUT, 0, 16'($urandom), 16'($urandom));
    else            plan(k, K_ABORT, int'($urandom_range(2, 5)), 16'($urandom), 16'($urandom));
  endtask

  // All requesters of a round are raised together, so they are served in rotation order from the pointer.
  task automatic launch(input logic [N-1:0] mask);
    exp_t e;
    int   last;
    last = modelPtr;
    for (int s = 0; s < N; s++) begin
      int k;
      k = (modelPtr + s) % N;
      if (mask[k]) begin
        e.idx   = k;
        e.regv  = reqReg[16*k +: 16];
        e.datav = reqData[16*k +: 16];
        e.kind  = planKind[k];
        e.lat   = (planKind[k] == K_NORMAL) ? planParam[k] + 1 :
                  (planKind[k] == K_TIMEOUT) ? TMO : planParam[k] + 1;
        sbq.push_back(e);
        last = k;
      end
    end
    modelPtr = (last + 1) % N;
    reqRunStart = reqRunStart | mask;
  endtask

  task automatic runRound();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      stepAgents();
      if (reqRunStart == '0 && !engBusy && !iowRunEnd && grant == '0 && sbq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL round_completion: got %0d outstanding transactions, expected 0", sbq.size());
    end
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL global_timeout: got still running, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    rst = 1'b1; reqRunStart = '0; reqReg = '0; reqData = '0; iowRunEnd = 1'b0;
    repeat (2) @(negedge clk);

    // All three held from reset: order 0,1,2, then 0 and 1 again: 0 then 1.
    plan(0, K_NORMAL, 2, 16'h0010, 16'hA000);
    plan(1, K_NORMAL, 3, 16'h0011, 16'hA001);
    plan(2, K_NORMAL, 4, 16'h0012, 16'hA002);
    launch(3'b111);
    @(negedge clk); rst = 1'b0;
    runRound();
    plan(0, K_NORMAL, 1, 16'h0020, 16'hB000);
    plan(1, K_NORMAL, 2, 16'h0021, 16'hB001);
    launch(3'b011);
    runRound();

    // Single request: RunStart one cycle after the request is seen.
    plan(0, K_NORMAL, 5, 16'h000C, 16'h0055);
    launch(3'b001);
    @(posedge clk); #1;
    chk("start_latency", 64'(iowRunStart), 64'(1));
    runRound();

    // Data changes during ISSUE ignored; RunEnd on the last possible cycle beats the watchdog.
    plan(1, K_NORMAL, TMO - 1, 16'h0004, 16'h1234);
    launch(3'b010);
    runRound();

    // Requester 2 aborts, requester 0 follows.
    plan(2, K_ABORT, 3, 16'h0030, 16'hC002);
    plan(0, K_NORMAL, 2, 16'h0031, 16'hC000);
    launch(3'b101);
    runRound();

    // Silent engine: watchdog forces completion.
    plan(1, K_TIMEOUT, 0, 16'h0040, 16'hD001);
    launch(3'b010);
    runRound();

    for (int r = 0; r < 30; r++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) if (m[k]) randPlan(k);
      launch(m);
      runRound();
    end

    // Reset in ISSUE: everything drops at once, held req0 is re-granted afterwards.
    plan(0, K_TIMEOUT, 0, 16'h00AA, 16'h1111);
    launch(3'b001);
    seen = 0;
    for (int c = 0; c < 60 && seen < 4; c++) begin
      @(negedge clk);
      stepAgents();
      if (iowRunStart) seen++;
    end
    #3 rst = 1'b1;
    #1 chk("async_reset_immediate",
           64'({grant, reqRunEnd, timeoutP, iowRunStart, iowReg, iowData}), 64'(0));
    sbq.delete();
    engBusy = 1'b0; iowRunEnd = 1'b0; modelPtr = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    plan(0, K_NORMAL, 3, reqReg[15:0], reqData[15:0]);
    launch(3'b001);
    runRound();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
